// File: rtl/cpu_control_sequencer_pkg.sv
// Shared state encoding, opcode constants and EXEC strobe decode for the
// CPU control sequencer.
package cpu_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  localparam logic [3:0] OPC_HALT = 4'd0;
  localparam logic [3:0] OPC_LD   = 4'd1;
  localparam logic [3:0] OPC_ST   = 4'd2;
  localparam logic [3:0] OPC_JMP  = 4'd3;
  localparam logic [3:0] OPC_BRZ  = 4'd4;

  typedef enum logic [2:0] {
    OPK_ALU,
    OPK_LD,
    OPK_ST,
    OPK_JMP,
    OPK_BRZ
  } opk_t;

  typedef struct packed {
    logic adr_sel;
    logic pc_ld;
    logic pc_inc;
    logic ir_ld;
    logic reg_w_en;
    logic s_sel;
    logic mem_w_en;
  } ctrl_t;

  function automatic ctrl_t exec_ctrl(input opk_t kind, input logic z);
    ctrl_t c;
    c = '0;
    case (kind)
      OPK_LD: begin
        c.adr_sel  = 1'b1;
        c.s_sel    = 1'b1;
        c.reg_w_en = 1'b1;
      end
      OPK_ST: begin
        c.adr_sel  = 1'b1;
        c.mem_w_en = 1'b1;
      end
      OPK_JMP: c.pc_ld = 1'b1;
      OPK_BRZ: c.pc_ld = z;
      default: c.reg_w_en = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cpu_control_sequencer_edge_detect.sv
// Registered rising-edge detector: one-cycle pulse the clock after din rises.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic din_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      din_q <= 1'b0;
      pulse <= 1'b0;
    end else begin
      din_q <= din;
      pulse <= din & ~din_q;
    end
  end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Fetch/decode/execute sequencer with single-step, free-run, PC breakpoint,
// HALT opcode and retired-instruction counter. All outputs are registered.
module cpu_control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned OPC_W  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_req,
  input  logic              run_mode,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] ir,
  input  logic              z_flag,
  output logic              adr_sel,
  output logic              pc_ld,
  output logic              pc_inc,
  output logic              ir_ld,
  output logic              reg_w_en,
  output logic              s_sel,
  output logic              mem_w_en,
  output logic              halted,
  output logic              bp_hit,
  output logic [2:0]        state_dbg,
  output logic [CNT_W-1:0]  instr_cnt
);

  logic             step_pulse;
  logic [2:0]       state_q, state_n;
  ctrl_t            ctrl_q, ctrl_n;
  logic             halted_n, bp_hit_n;
  logic             resume_q, resume_n;
  logic             go, bp_match, is_halt;
  logic [OPC_W-1:0] opc;
  opk_t             opk;
  logic             ir_unused;

  edge_detect u_step_edge (
    .clk   (clk),
    .reset (reset),
    .din   (step_req),
    .pulse (step_pulse)
  );

  assign opc       = ir[DATA_W-1 -: OPC_W];
  assign ir_unused = ^ir[DATA_W-OPC_W-1:0];
  assign go        = run_mode | step_pulse;
  assign bp_match  = bp_en && (pc == bp_addr);
  assign is_halt   = (opc == OPC_W'(OPC_HALT));

  always_comb begin
    opk = OPK_ALU;
    if (opc == OPC_W'(OPC_LD))       opk = OPK_LD;
    else if (opc == OPC_W'(OPC_ST))  opk = OPK_ST;
    else if (opc == OPC_W'(OPC_JMP)) opk = OPK_JMP;
    else if (opc == OPC_W'(OPC_BRZ)) opk = OPK_BRZ;
  end

  always_comb begin
    state_n  = state_q;
    ctrl_n   = '0;
    halted_n = halted;
    bp_hit_n = bp_hit;
    resume_n = resume_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_n  = ST_FETCH;
          resume_n = 1'b1;
          bp_hit_n = 1'b0;
        end
      end
      ST_FETCH: begin
        state_n  = ST_DECODE;
        resume_n = 1'b0;
      end
      ST_DECODE: begin
        if (is_halt) begin
          state_n  = ST_HALT;
          halted_n = 1'b1;
        end else begin
          state_n = ST_EXEC;
          ctrl_n  = exec_ctrl(opk, z_flag);
        end
      end
      ST_EXEC: state_n = run_mode ? ST_FETCH : ST_IDLE;
      ST_HALT: state_n = ST_HALT;
      default: state_n = ST_IDLE;
    endcase
    // Every path into FETCH shares the breakpoint gate, so a blocked fetch
    // parks in IDLE without ever raising a fetch strobe.
    if (state_n == ST_FETCH) begin
      if (bp_match && !resume_n) begin
        state_n  = ST_IDLE;
        bp_hit_n = 1'b1;
      end else begin
        ctrl_n.ir_ld  = 1'b1;
        ctrl_n.pc_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      halted    <= 1'b0;
      bp_hit    <= 1'b0;
      resume_q  <= 1'b0;
      instr_cnt <= '0;
    end else begin
      state_q  <= state_n;
      ctrl_q   <= ctrl_n;
      halted   <= halted_n;
      bp_hit   <= bp_hit_n;
      resume_q <= resume_n;
      if (state_q == ST_EXEC) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  assign adr_sel   = ctrl_q.adr_sel;
  assign pc_ld     = ctrl_q.pc_ld;
  assign pc_inc    = ctrl_q.pc_inc;
  assign ir_ld     = ctrl_q.ir_ld;
  assign reg_w_en  = ctrl_q.reg_w_en;
  assign s_sel     = ctrl_q.s_sel;
  assign mem_w_en  = ctrl_q.mem_w_en;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Self-checking bench: a per-instruction expectation model queues the
// required outputs for every cycle; one negedge process compares them.
module tb_cpu_control_sequencer;

  localparam int unsigned CW = 4;
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC = 3'd3, S_HALT = 3'd4;
  localparam logic [6:0] STRB_NONE  = 7'b0000000;
  localparam logic [6:0] STRB_FETCH = 7'b0011000;

  logic          clk, reset, step_req, run_mode, bp_en, z_flag;
  logic [15:0]   bp_addr, pc, ir;
  logic          adr_sel, pc_ld, pc_inc, ir_ld, reg_w_en, s_sel, mem_w_en;
  logic          halted, bp_hit;
  logic [2:0]    state_dbg;
  logic [CW-1:0] instr_cnt;

  cpu_control_sequencer #(.DATA_W(16), .ADDR_W(16), .OPC_W(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .step_req(step_req), .run_mode(run_mode),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .ir(ir), .z_flag(z_flag),
    .adr_sel(adr_sel), .pc_ld(pc_ld), .pc_inc(pc_inc), .ir_ld(ir_ld),
    .reg_w_en(reg_w_en), .s_sel(s_sel), .mem_w_en(mem_w_en),
    .halted(halted), .bp_hit(bp_hit), .state_dbg(state_dbg), .instr_cnt(instr_cnt)
  );

  typedef struct {
    logic [2:0]    st;
    logic [6:0]    strb;
    logic          halted;
    logic          bp;
    logic [CW-1:0] cnt;
    logic          pin_en;
    logic [2:0]    pin_st;
    logic [CW-1:0] pin_cnt;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          cur;
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [CW-1:0] m_cnt;
  logic          m_halted, m_bp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("state",   16'(state_dbg), 16'(cur.st));
      chk("strobes", 16'({adr_sel, pc_ld, pc_inc, ir_ld, reg_w_en, s_sel, mem_w_en}),
          16'(cur.strb));
      chk("halted",    16'(halted), 16'(cur.halted));
      chk("bp_hit",    16'(bp_hit), 16'(cur.bp));
      chk("instr_cnt", 16'(instr_cnt), 16'(cur.cnt));
      chk("pc_ld_pc_inc_excl", 16'(pc_ld & pc_inc), 16'h0);
      chk("mem_reg_w_excl", 16'(mem_w_en & reg_w_en), 16'h0);
      if (cur.pin_en) begin
        chk("pin_state", 16'(state_dbg), 16'(cur.pin_st));
        chk("pin_cnt",   16'(instr_cnt), 16'(cur.pin_cnt));
      end
    end
  end

  function automatic logic [6:0] exec_strb(input logic [3:0] opc, input logic z);
    case (opc)
      4'd1:    return 7'b1000110;
      4'd2:    return 7'b1000001;
      4'd3:    return 7'b0100000;
      4'd4:    return {1'b0, z, 5'b00000};
      default: return 7'b0000100;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input logic [2:0] st, input logic [6:0] strb);
    exp_t e;
    e.st = st; e.strb = strb; e.halted = m_halted; e.bp = m_bp; e.cnt = m_cnt;
    e.pin_en = 1'b0; e.pin_st = 3'd0; e.pin_cnt = '0;
    exp_q.push_back(e);
    tick();
  endtask

  task automatic pin(input logic [2:0] st, input logic [CW-1:0] cnt);
    exp_t e;
    e = exp_q.pop_back();
    e.pin_en = 1'b1; e.pin_st = st; e.pin_cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_cnt = '0; m_halted = 1'b0; m_bp = 1'b0;
    slot(S_IDLE, STRB_NONE);
    reset = 1'b0;
    pin(S_IDLE, '0);
  endtask

  task automatic step_go();
    step_req = 1'b1;
    slot(S_IDLE, STRB_NONE);
    step_req = 1'b0;
  endtask

  // One instruction from FETCH onward; returns in its EXEC (or HALT) cycle.
  task automatic instr(input logic [3:0] opc, input logic z, input logic run_after,
                       input logic poke_decode);
    ir = {opc, 12'h5a3};
    z_flag = z;
    m_bp = 1'b0;
    slot(S_FETCH, STRB_FETCH);
    slot(S_DECODE, STRB_NONE);
    pc = pc + 16'd1;
    if (poke_decode) step_req = 1'b1;
    if (opc == 4'd0) begin
      m_halted = 1'b1;
      slot(S_HALT, STRB_NONE);
      return;
    end
    slot(S_EXEC, exec_strb(opc, z));
    run_mode = run_after;
    m_cnt = m_cnt + 1'b1;
    if (run_after && bp_en && pc == bp_addr) m_bp = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at %0t: got timeout expected finish", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; step_req = 1'b0; run_mode = 1'b0; bp_en = 1'b0; z_flag = 1'b0;
    bp_addr = 16'h0; pc = 16'h0; ir = 16'h0;
    m_cnt = '0; m_halted = 1'b0; m_bp = 1'b0;

    do_reset();
    slot(S_IDLE, STRB_NONE);

    // LD in step mode; a second edge raised during DECODE must be dropped
    step_go();
    instr(4'd1, 1'b0, 1'b0, 1'b1);
    slot(S_IDLE, STRB_NONE);
    pin(S_IDLE, 4'd1);
    step_req = 1'b0;
    slot(S_IDLE, STRB_NONE);
    slot(S_IDLE, STRB_NONE);

    // reset while ST is in EXEC
    step_go();
    instr(4'd2, 1'b0, 1'b0, 1'b0);
    do_reset();
    slot(S_IDLE, STRB_NONE);

    // BRZ not taken, BRZ taken, JMP
    step_go();
    instr(4'd4, 1'b0, 1'b0, 1'b0);
    slot(S_IDLE, STRB_NONE);
    step_go();
    instr(4'd4, 1'b1, 1'b0, 1'b0);
    slot(S_IDLE, STRB_NONE);
    step_go();
    instr(4'd3, 1'b0, 1'b0, 1'b0);
    slot(S_IDLE, STRB_NONE);
    pin(S_IDLE, 4'd3);

    // free run: ten ALU instructions in thirty cycles
    do_reset();
    run_mode = 1'b1;
    for (int unsigned i = 0; i < 10; i++) instr(4'd5, 1'b0, i < 9, 1'b0);
    slot(S_IDLE, STRB_NONE);
    pin(S_IDLE, 4'd10);

    // breakpoint at 0x0004 in free run, then resume with a step
    do_reset();
    pc = 16'h0; bp_en = 1'b1; bp_addr = 16'h0004;
    slot(S_IDLE, STRB_NONE);
    run_mode = 1'b1;
    for (int unsigned i = 0; i < 4; i++) instr(4'd6, 1'b0, 1'b1, 1'b0);
    slot(S_IDLE, STRB_NONE);
    pin(S_IDLE, 4'd4);
    run_mode = 1'b0;
    slot(S_IDLE, STRB_NONE);
    step_go();
    instr(4'd7, 1'b0, 1'b0, 1'b0);
    slot(S_IDLE, STRB_NONE);
    pin(S_IDLE, 4'd5);
    bp_en = 1'b0;

    // HALT is sticky against step edges and run mode
    do_reset();
    slot(S_IDLE, STRB_NONE);
    step_go();
    instr(4'd0, 1'b0, 1'b0, 1'b0);
    pin(S_HALT, 4'd0);
    step_req = 1'b1;
    slot(S_HALT, STRB_NONE);
    step_req = 1'b0;
    slot(S_HALT, STRB_NONE);
    run_mode = 1'b1;
    slot(S_HALT, STRB_NONE);
    slot(S_HALT, STRB_NONE);
    slot(S_HALT, STRB_NONE);
    run_mode = 1'b0;

    // 16 retirements wrap a 4-bit counter back to zero
    do_reset();
    run_mode = 1'b1;
    for (int unsigned i = 0; i < 16; i++) instr(4'd8, 1'b0, i < 15, 1'b0);
    slot(S_IDLE, STRB_NONE);
    pin(S_IDLE, 4'd0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
